// File: rtl/decode_exe_stage.sv
// Decode-to-execute pipeline stage: integer register file with write-back bypass,
// EX pipeline register behind a valid/ready handshake, load-use bubbles and a hazard counter.
module decode_exe_stage #(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREGS  = 32,
  parameter  int unsigned CTRL_W = 20,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned RA     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              de_valid,
  output logic              de_ready,
  input  logic [XLEN-1:0]   de_pc,
  input  logic [RA-1:0]     de_rs1,
  input  logic [RA-1:0]     de_rs2,
  input  logic [RA-1:0]     de_rd,
  input  logic [XLEN-1:0]   de_imm,
  input  logic [CTRL_W-1:0] de_ctrl,
  input  logic              de_mem_read,
  input  logic              de_reg_write,
  input  logic              wb_we,
  input  logic [RA-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_pc_plus4,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RA-1:0]     ex_rs1,
  output logic [RA-1:0]     ex_rs2,
  output logic [RA-1:0]     ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  hazard_cnt
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [RA-1:0]     rs1;
    logic [RA-1:0]     rs2;
    logic [RA-1:0]     rd;
    logic [CTRL_W-1:0] ctrl;
    logic              mem_read;
    logic              reg_write;
  } ex_bundle_t;

  ex_bundle_t      ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  logic            hold;
  logic            hazard;
  logic [XLEN-1:0] rd1_c;
  logic [XLEN-1:0] rd2_c;

  // Register file write port; r0 is never written so it stays at its reset value of 0.
  always_comb begin
    rf_d = rf_q;
    if (wb_we && (wb_rd != '0)) begin
      rf_d[wb_rd] = wb_result;
    end
  end

  // Operand read with same-cycle write-back bypass.
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (de_rs1 != '0) begin
      rd1_c = (wb_we && (wb_rd == de_rs1)) ? wb_result : rf_q[de_rs1];
    end
    if (de_rs2 != '0) begin
      rd2_c = (wb_we && (wb_rd == de_rs2)) ? wb_result : rf_q[de_rs2];
    end
  end

  // Handshake and load-use detection; de_ready deliberately has no path from wb_*.
  always_comb begin
    hold     = ex_q.valid & ~ex_ready;
    hazard   = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & de_valid &
               ((ex_q.rd == de_rs1) | (ex_q.rd == de_rs2));
    de_ready = ~reset & (flush | (~hold & ~hazard));
  end

  // EX slot next state: flush > hold > hazard bubble > load > idle bubble.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
      if (!(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (de_valid) begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = de_pc;
      ex_d.pc_plus4  = de_pc + XLEN'(4);
      ex_d.rd1       = rd1_c;
      ex_d.rd2       = rd2_c;
      ex_d.imm       = de_imm;
      ex_d.rs1       = de_rs1;
      ex_d.rs2       = de_rs2;
      ex_d.rd        = de_rd;
      ex_d.ctrl      = de_ctrl;
      ex_d.mem_read  = de_mem_read;
      ex_d.reg_write = de_reg_write;
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
      rf_q  <= '{default: '0};
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
      rf_q  <= rf_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_pc_plus4  = ex_q.pc_plus4;
  assign ex_rd1       = ex_q.rd1;
  assign ex_rd2       = ex_q.rd2;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_reg_write = ex_q.reg_write;
  assign hazard_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_exe_stage.sv
// Directed bench for decode_exe_stage: expected EX contents are queued as each cycle is
// driven and popped after the following rising edge.
module tb_decode_exe_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned CTRL_W = 20;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned RA     = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              de_valid, de_ready;
  logic [XLEN-1:0]   de_pc, de_imm;
  logic [RA-1:0]     de_rs1, de_rs2, de_rd;
  logic [CTRL_W-1:0] de_ctrl;
  logic              de_mem_read, de_reg_write;
  logic              wb_we;
  logic [RA-1:0]     wb_rd;
  logic [XLEN-1:0]   wb_result;
  logic              flush, ex_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
  logic [RA-1:0]     ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_mem_read, ex_reg_write;
  logic [CNT_W-1:0]  hazard_cnt;

  decode_exe_stage #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_ready(de_ready), .de_pc(de_pc),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd), .de_imm(de_imm), .de_ctrl(de_ctrl),
    .de_mem_read(de_mem_read), .de_reg_write(de_reg_write),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [RA-1:0]     rs1;
    logic [RA-1:0]     rs2;
    logic [RA-1:0]     rd;
    logic [CTRL_W-1:0] ctrl;
    logic              mr;
    logic              rw;
  } exp_t;

  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_bubble();
    exp_q.push_back('0);
  endtask

  // Expected EX contents for the instruction currently driven on de_*.
  task automatic push_instr(input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2);
    exp_t e;
    e.valid = 1'b1;
    e.pc    = de_pc;
    e.pc4   = de_pc + 32'd4;
    e.rd1   = rd1;
    e.rd2   = rd2;
    e.imm   = de_imm;
    e.rs1   = de_rs1;
    e.rs2   = de_rs2;
    e.rd    = de_rd;
    e.ctrl  = de_ctrl;
    e.mr    = de_mem_read;
    e.rw    = de_reg_write;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [XLEN-1:0] pc, input logic [RA-1:0] rs1,
                       input logic [RA-1:0] rs2, input logic [RA-1:0] rd,
                       input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl,
                       input logic mr, input logic rw);
    de_valid = 1'b1; de_pc = pc; de_rs1 = rs1; de_rs2 = rs2; de_rd = rd;
    de_imm = imm; de_ctrl = ctrl; de_mem_read = mr; de_reg_write = rw;
  endtask

  task automatic check_ready(input string tag, input logic expv);
    #1;
    check(tag, 32'(de_ready), 32'(expv));
  endtask

  // Advance one edge, then pop the expected EX slot and compare every field.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s.queue: observed empty scoreboard expected one entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
      check({tag, ".pc"}, ex_pc, e.pc);
      check({tag, ".pc4"}, ex_pc_plus4, e.pc4);
      check({tag, ".rd1"}, ex_rd1, e.rd1);
      check({tag, ".rd2"}, ex_rd2, e.rd2);
      check({tag, ".imm"}, ex_imm, e.imm);
      check({tag, ".rs1"}, 32'(ex_rs1), 32'(e.rs1));
      check({tag, ".rs2"}, 32'(ex_rs2), 32'(e.rs2));
      check({tag, ".rd"}, 32'(ex_rd), 32'(e.rd));
      check({tag, ".ctrl"}, 32'(ex_ctrl), 32'(e.ctrl));
      check({tag, ".mr"}, 32'(ex_mem_read), 32'(e.mr));
      check({tag, ".rw"}, 32'(ex_reg_write), 32'(e.rw));
    end
    check({tag, ".hcnt"}, 32'(hazard_cnt), 32'(exp_cnt));
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  initial begin
    // Reset for two cycles with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      de_valid = 1'($urandom); de_pc = $urandom; de_rs1 = 5'($urandom);
      de_rs2 = 5'($urandom); de_rd = 5'($urandom); de_imm = $urandom;
      de_ctrl = 20'($urandom); de_mem_read = 1'($urandom); de_reg_write = 1'($urandom);
      wb_we = 1'b1; wb_rd = 5'($urandom_range(1, 31)); wb_result = $urandom;
      flush = 1'($urandom); ex_ready = 1'($urandom);
      check_ready("reset_ready", 1'b0);
      push_bubble();
      tick("reset");
    end
    reset = 1'b0; wb_we = 1'b0; flush = 1'b0; ex_ready = 1'b1;

    // Registers read zero after reset
    issue(32'h0, 5'd3, 5'd31, 5'd1, 32'h0, 20'h11, 1'b0, 1'b1);
    check_ready("rf_zero_ready", 1'b1);
    push_instr(32'h0, 32'h0);
    tick("rf_zero_a");
    issue(32'h4, 5'd5, 5'd7, 5'd1, 32'h0, 20'h12, 1'b0, 1'b1);
    push_instr(32'h0, 32'h0);
    tick("rf_zero_b");

    // Same-cycle write-back bypass
    wb_we = 1'b1; wb_rd = 5'd5; wb_result = 32'hDEADBEEF;
    issue(32'h10, 5'd5, 5'd0, 5'd2, 32'h4, 20'h21, 1'b0, 1'b1);
    push_instr(32'hDEADBEEF, 32'h0);
    tick("bypass");
    wb_rd = 5'd0; wb_result = 32'h1234;
    issue(32'h14, 5'd0, 5'd5, 5'd3, 32'h0, 20'h22, 1'b0, 1'b1);
    push_instr(32'h0, 32'hDEADBEEF);
    tick("r0_write");
    wb_we = 1'b0;

    // Load-use: load r7, dependent rs2=7, write-back of r7 during the stall
    issue(32'h18, 5'd5, 5'd0, 5'd7, 32'h8, 20'h31, 1'b1, 1'b1);
    push_instr(32'hDEADBEEF, 32'h0);
    tick("load");
    issue(32'h1C, 5'd0, 5'd7, 5'd8, 32'h0, 20'h32, 1'b0, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd7; wb_result = 32'hCAFEF00D;
    check_ready("lu_stall_ready", 1'b0);
    push_bubble();
    exp_cnt = sat_inc(exp_cnt);
    tick("lu_bubble");
    wb_we = 1'b0;
    check_ready("lu_issue_ready", 1'b1);
    push_instr(32'h0, 32'hCAFEF00D);
    tick("lu_issue");

    // Load with rd=0 never stalls
    issue(32'h20, 5'd1, 5'd2, 5'd0, 32'h0, 20'h41, 1'b1, 1'b0);
    push_instr(32'h0, 32'h0);
    tick("load_r0");
    issue(32'h24, 5'd0, 5'd0, 5'd4, 32'h0, 20'h42, 1'b0, 1'b1);
    check_ready("load_r0_ready", 1'b1);
    push_instr(32'h0, 32'h0);
    tick("load_r0_dep");

    // Back-pressure holds the EX slot
    issue(32'h100, 5'd7, 5'd5, 5'd9, 32'h55, 20'h51, 1'b0, 1'b1);
    push_instr(32'hCAFEF00D, 32'hDEADBEEF);
    tick("bp_load");
    begin
      exp_t held;
      held = exp_q.size() == 0 ? '0 : '0;
      held.valid = 1'b1; held.pc = 32'h100; held.pc4 = 32'h104; held.rd1 = 32'hCAFEF00D;
      held.rd2 = 32'hDEADBEEF; held.imm = 32'h55; held.rs1 = 5'd7; held.rs2 = 5'd5;
      held.rd = 5'd9; held.ctrl = 20'h51; held.mr = 1'b0; held.rw = 1'b1;
      issue(32'h104, 5'd0, 5'd0, 5'd10, 32'h0, 20'h52, 1'b0, 1'b1);
      ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check_ready("bp_ready", 1'b0);
        exp_q.push_back(held);
        tick("bp_hold");
      end
    end
    ex_ready = 1'b1;
    check_ready("bp_release_ready", 1'b1);
    push_instr(32'h0, 32'h0);
    tick("bp_release");

    // Flush beats hold and discards the decode slot
    ex_ready = 1'b0; flush = 1'b1;
    issue(32'h200, 5'd1, 5'd2, 5'd11, 32'h9, 20'hABCDE, 1'b0, 1'b1);
    check_ready("flush_ready", 1'b1);
    push_bubble();
    tick("flush");
    flush = 1'b0; ex_ready = 1'b1; de_valid = 1'b0;
    push_bubble();
    tick("flush_after");

    // Five load-use hazards saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      issue(32'h300 + 32'(i * 16), 5'd0, 5'd0, 5'd10, 32'h0, 20'h61, 1'b1, 1'b1);
      push_instr(32'h0, 32'h0);
      tick("sat_load");
      issue(32'h304 + 32'(i * 16), 5'd10, 5'd0, 5'd12, 32'h0, 20'h62, 1'b0, 1'b1);
      check_ready("sat_stall_ready", 1'b0);
      push_bubble();
      exp_cnt = sat_inc(exp_cnt);
      tick("sat_bubble");
      push_instr(32'h0, 32'h0);
      tick("sat_issue");
    end
    check("sat_final", 32'(hazard_cnt), 32'd3);

    // PC+4 wraps at the top of the address space
    issue(32'hFFFFFFFC, 5'd0, 5'd0, 5'd13, 32'h0, 20'h71, 1'b0, 1'b1);
    push_instr(32'h0, 32'h0);
    tick("pc_wrap");
    check("pc_wrap_zero", ex_pc_plus4, 32'h0);

    // Reset mid-stream empties EX and clears the counter
    issue(32'h400, 5'd0, 5'd0, 5'd14, 32'h0, 20'h81, 1'b0, 1'b1);
    reset = 1'b1;
    check_ready("midreset_ready", 1'b0);
    push_bubble();
    exp_cnt = '0;
    tick("midreset");
    reset = 1'b0;
    issue(32'h404, 5'd5, 5'd7, 5'd15, 32'h0, 20'h82, 1'b0, 1'b1);
    push_instr(32'h0, 32'h0);
    tick("after_midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
